// File: rtl/perf_pkg.sv
// rtl/perf_pkg.sv - shared state encoding and select constants for the perf counter unit
package perf_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FROZEN = 2'd2
    } perf_state_e;

    localparam int CYC_SEL = 0;

endpackage

// File: rtl/perf_cnt.sv
// rtl/perf_cnt.sv - one counter with enable, sync clear and sticky overflow
// PERF_SATURATE_EN: overflow sticks at all-ones instead of wrapping to zero
module perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_ovf
);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_cnt <= '0;
            o_ovf <= 1'b0;
        end else if (i_clr) begin
            o_cnt <= '0;
            o_ovf <= 1'b0;
        end else if (i_en) begin
            if (&o_cnt) begin
                o_ovf <= 1'b1;
`ifdef PERF_SATURATE_EN
                o_cnt <= o_cnt;
`else
                o_cnt <= '0;
`endif
            end else begin
                o_cnt <= o_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/perf_counter_unit.sv
// rtl/perf_counter_unit.sv - windowed cycle/event counters with registered read port
// PERF_SATURATE_EN selects saturating counters (see perf_cnt)
module perf_counter_unit
    import perf_pkg::*;
#(
    parameter int  NUM_EVT = 4,
    parameter int  CNT_W   = 32,
    localparam int SEL_W   = $clog2(NUM_EVT + 1)
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic               i_clr,
    input  logic [NUM_EVT-1:0] i_evt,
    input  logic [SEL_W-1:0]   i_rd_sel,
    input  logic               i_rd_req,
    output logic [CNT_W-1:0]   o_rd_data,
    output logic               o_rd_vld,
    output logic [NUM_EVT:0]   o_ovf,
    output logic               o_running,
    output logic               o_done
);

    perf_state_e state_q, state_d;
    logic        run_en;
    logic [NUM_EVT:0]  cnt_en;
    logic [CNT_W-1:0]  cnt [NUM_EVT+1];
    logic [CNT_W-1:0]  rd_mux;

    always_comb begin
        state_d = state_q;
        if (i_clr) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (i_start) state_d = RUN;
                RUN:     if (i_stop)  state_d = FROZEN;
                default: state_d = state_q;
            endcase
        end
    end

    // Flags are decoded from the next state so they move on the same edge as the state
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= IDLE;
            o_running <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            state_q   <= state_d;
            o_running <= (state_d == RUN);
            o_done    <= (state_d == FROZEN);
        end
    end

    assign run_en = (state_q == RUN);

    always_comb begin
        cnt_en = '0;
        cnt_en[CYC_SEL] = run_en;
        for (int k = 0; k < NUM_EVT; k++) begin
            cnt_en[CYC_SEL + 1 + k] = run_en & i_evt[k];
        end
    end

    for (genvar g = 0; g <= NUM_EVT; g++) begin : g_cnt
        perf_cnt #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_clr   (i_clr),
            .i_en    (cnt_en[g]),
            .o_cnt   (cnt[g]),
            .o_ovf   (o_ovf[g])
        );
    end

    // Unmatched selects fall through to zero
    always_comb begin
        rd_mux = '0;
        for (int k = 0; k <= NUM_EVT; k++) begin
            if (i_rd_sel == SEL_W'(k)) rd_mux = cnt[k];
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_rd_data <= '0;
            o_rd_vld  <= 1'b0;
        end else begin
            o_rd_vld <= i_rd_req;
            if (i_rd_req) o_rd_data <= rd_mux;
        end
    end

endmodule

// File: tb/tb_perf_counter_unit.sv
// tb/tb_perf_counter_unit.sv - scoreboard bench for perf_counter_unit (CNT_W=4, honours PERF_SATURATE_EN)
module tb_perf_counter_unit;
    import perf_pkg::*;

    localparam int NUM_EVT = 4;
    localparam int CNT_W   = 4;
    localparam int SEL_W   = 3;
`ifdef PERF_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start, stop, clr, rd_req;
    logic [NUM_EVT-1:0] evt;
    logic [SEL_W-1:0]   rd_sel;
    logic [CNT_W-1:0]   rd_data;
    logic               rd_vld, running, done;
    logic [NUM_EVT:0]   ovf;

    int errors = 0;
    int checks = 0;

    logic [CNT_W-1:0] exp_q[$];
    perf_state_e      m_state;
    logic [CNT_W-1:0] m_cnt [NUM_EVT+1];
    logic [NUM_EVT:0] m_ovf;
    bit               use_const;
    logic [CNT_W-1:0] const_exp;

    always #5 clk = ~clk;

    perf_counter_unit #(
        .NUM_EVT (NUM_EVT),
        .CNT_W   (CNT_W)
    ) dut (
        .i_clk     (clk),
        .i_reset   (rst_n),
        .i_start   (start),
        .i_stop    (stop),
        .i_clr     (clr),
        .i_evt     (evt),
        .i_rd_sel  (rd_sel),
        .i_rd_req  (rd_req),
        .o_rd_data (rd_data),
        .o_rd_vld  (rd_vld),
        .o_ovf     (ovf),
        .o_running (running),
        .o_done    (done)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [CNT_W-1:0] model_read(input logic [SEL_W-1:0] sel);
        if (int'(sel) <= NUM_EVT) return m_cnt[sel];
        return '0;
    endfunction

    task automatic model_inc(input int idx);
        if (&m_cnt[idx]) begin
            m_ovf[idx] = 1'b1;
            m_cnt[idx] = SAT ? m_cnt[idx] : '0;
        end else begin
            m_cnt[idx] = m_cnt[idx] + 1'b1;
        end
    endtask

    task automatic model_reset();
        m_state = IDLE;
        m_ovf   = '0;
        for (int i = 0; i <= NUM_EVT; i++) m_cnt[i] = '0;
        exp_q.delete();
    endtask

    task automatic model_update();
        if (clr) begin
            m_state = IDLE;
            m_ovf   = '0;
            for (int i = 0; i <= NUM_EVT; i++) m_cnt[i] = '0;
        end else begin
            if (m_state == RUN) begin
                model_inc(0);
                for (int k = 0; k < NUM_EVT; k++) if (evt[k]) model_inc(k + 1);
            end
            if (m_state == IDLE && start) m_state = RUN;
            else if (m_state == RUN && stop) m_state = FROZEN;
        end
    endtask

    task automatic clear_inputs();
        start = 0; stop = 0; clr = 0; rd_req = 0; evt = '0; rd_sel = '0; use_const = 0;
    endtask

    task automatic cycle();
        logic exp_vld;
        logic [CNT_W-1:0] e;
        exp_vld = rd_req;
        if (rd_req) exp_q.push_back(use_const ? const_exp : model_read(rd_sel));
        @(posedge clk);
        model_update();
        #1;
        chk("rd_vld", rd_vld, exp_vld);
        if (exp_vld) begin
            if (exp_q.size() == 0) chk("rd_queue_empty", 1, 0);
            else begin
                e = exp_q.pop_front();
                if (rd_vld === 1'b1) chk("rd_data", rd_data, e);
            end
        end
        chk("running", running, m_state == RUN);
        chk("done", done, m_state == FROZEN);
        chk("ovf", ovf, m_ovf);
        clear_inputs();
    endtask

    task automatic read_const(input logic [SEL_W-1:0] sel, input logic [CNT_W-1:0] exp);
        rd_sel = sel; rd_req = 1; use_const = 1; const_exp = exp;
        cycle();
    endtask

    initial begin
        logic [9:0] pat;
        pat = 10'b1011010110;
        clear_inputs();
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_vld", rd_vld, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_running", running, 0);
        chk("rst_done", done, 0);
        #3 rst_n = 1;

        // Window: 10 RUN cycles, evt[0] on 6 of them, stop on the 10th
        start = 1; cycle();
        for (int i = 0; i < 10; i++) begin
            evt[0] = pat[i];
            stop = (i == 9);
            cycle();
        end
        chk("win_done", done, 1);
        read_const(0, 10);
        read_const(1, 6);
        read_const(2, 0);
        read_const(3'd7, 0);

        // Edge cycles: events on start and stop cycles, only stop cycle counts
        clr = 1; evt = '1; cycle();
        start = 1; evt = '1; cycle();
        for (int i = 0; i < 7; i++) begin
            evt = '1; stop = (i == 6); cycle();
        end
        read_const(0, 7);
        read_const(1, 7);
        read_const(4, 7);

        // Priority: clr beats start while FROZEN; read same cycle sees pre-clear value
        clr = 1; start = 1; read_const(3, 7);
        chk("prio_running", running, 0);
        chk("prio_done", done, 0);
        chk("prio_ovf", ovf, 0);
        read_const(3, 0);
        read_const(0, 0);

        // Overflow: 17 events into 4-bit counters
        start = 1; cycle();
        for (int i = 0; i < 17; i++) begin
            evt[0] = 1; stop = (i == 16); cycle();
        end
        read_const(1, SAT ? 4'd15 : 4'd1);
        read_const(0, SAT ? 4'd15 : 4'd1);
        read_const(2, 0);
        chk("ovf_bits", ovf, 5'b00011);

        // Live reads during RUN, including back-to-back on the cycle counter
        clr = 1; cycle();
        start = 1; cycle();
        for (int i = 0; i < 3; i++) begin
            evt = NUM_EVT'($urandom_range(0, 15)); cycle();
        end
        for (int i = 0; i < 3; i++) begin
            rd_sel = 0; rd_req = 1; evt = NUM_EVT'($urandom_range(0, 15)); cycle();
        end
        for (int i = 0; i < 4; i++) begin
            rd_sel = SEL_W'($urandom_range(0, 5)); rd_req = 1;
            evt = NUM_EVT'($urandom_range(0, 15)); cycle();
        end

        // Async reset between edges with a read in flight
        rd_sel = 0; rd_req = 1;
        #2 rst_n = 0;
        #1;
        chk("arst_rd_data", rd_data, 0);
        chk("arst_rd_vld", rd_vld, 0);
        chk("arst_running", running, 0);
        chk("arst_done", done, 0);
        chk("arst_ovf", ovf, 0);
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst_n = 1;
        cycle();
        read_const(0, 0);
        start = 1; cycle();
        chk("resume_running", running, 1);
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got %0d expected %0d", 1, 0);
        $fatal(1);
    end

endmodule
